// File: rtl/mul4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul4_seq_ctrl
//
// Purpose:
//   Multi-cycle sequencer for the two-digit by two-digit unsigned multiply
//   {a1,a0} * {b1,b0} -> {y3,y2,y1,y0}.
//
//   A single WIDTH x WIDTH multiplier is shared across up to four partial
//   products. Each partial product is shifted into place and added into a
//   4*WIDTH-bit accumulator:
//
//       step0 : a0*b0
//       step1 : a0*b1 << WIDTH
//       step2 : a1*b0 << WIDTH
//       step3 : a1*b1 << 2*WIDTH
//
//   The full product always fits in 4*WIDTH bits, so the accumulator never
//   overflows.
//
//   Operands are captured when the input handshake completes, so changes on
//   a*/b* after that point have no effect on the result in progress.
//
// Build option:
//   MUL4_SEQ_ZERO_SKIP_EN
//     When defined, a step whose two digits are not both nonzero is skipped.
//     Such a step would only add zero.
//     - A 4-bit step mask is built when operands are accepted.
//     - Each MUL edge processes the lowest set mask bit, then clears it.
//     - An all-zero mask goes straight from IDLE to DONE with y = 0.
//     Results are identical in both builds; only latency changes.
//
// Ports:
//   clk        in   sole clock; all state updates on its rising edge
//   rst        in   synchronous, active-high reset (highest priority)
//   in_valid   in   operands a1/a0/b1/b0 are valid
//   in_ready   out  block can accept operands (IDLE)
//   a1, a0     in   high / low digit of A (WIDTH bits each)
//   b1, b0     in   high / low digit of B (WIDTH bits each)
//   out_valid  out  y3..y0 hold a completed product (DONE)
//   out_ready  in   consumer accepts the result
//   y3..y0     out  product digits, y3 is the most significant
//   busy       out  high while partial products are being accumulated (MUL)
// -----------------------------------------------------------------------------
module mul4_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b0,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y0,

    output logic             busy
);

    // Product and accumulator widths.
    localparam int PW = 2 * WIDTH;   // one partial product
    localparam int AW = 4 * WIDTH;   // accumulator / full result

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State registers and their next-state values
    // -------------------------------------------------------------------------

    // Control.
    logic [1:0]       state_reg, state_next;
    logic [1:0]       step_reg,  step_next;

    // Datapath.
    logic [AW-1:0]    acc_reg,   acc_next;
    logic [AW-1:0]    y_reg,     y_next;

    // Captured operands.
    logic [WIDTH-1:0] a1_reg,    a1_next;
    logic [WIDTH-1:0] a0_reg,    a0_next;
    logic [WIDTH-1:0] b1_reg,    b1_next;
    logic [WIDTH-1:0] b0_reg,    b0_next;

`ifdef MUL4_SEQ_ZERO_SKIP_EN
    // One bit per partial-product step still to be processed.
    logic [3:0]       mask_reg,  mask_next;
    logic [3:0]       accept_mask;
`endif

    // -------------------------------------------------------------------------
    // Step selection
    //
    //   cur_step  : which partial product the MUL edge handles
    //   last_step : this MUL edge completes the operation
    // -------------------------------------------------------------------------
    logic [1:0] cur_step;
    logic       last_step;

`ifdef MUL4_SEQ_ZERO_SKIP_EN
    // A step only contributes when both of its digits are nonzero.
    // Bit order matches the step number: {a1*b1, a1*b0, a0*b1, a0*b0}.
    assign accept_mask = {(a1 != '0) && (b1 != '0),
                          (a1 != '0) && (b0 != '0),
                          (a0 != '0) && (b1 != '0),
                          (a0 != '0) && (b0 != '0)};

    // Lowest set bit of the remaining mask selects the step. The loop runs
    // from the top bit down, so the lowest set bit is assigned last and wins.
    always_comb begin
        cur_step = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_reg[i]) begin
                cur_step = 2'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when one bit remains.
    assign last_step = ((mask_reg & (mask_reg - 4'd1)) == 4'd0);
`else
    assign cur_step  = step_reg;
    assign last_step = (step_reg == 2'd3);
`endif

    // -------------------------------------------------------------------------
    // Shared partial-product multiplier
    //
    // Step bit 1 picks the A digit and step bit 0 picks the B digit:
    //   00 -> a0*b0   01 -> a0*b1   10 -> a1*b0   11 -> a1*b1
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [PW-1:0]    pp;

    assign op_a = cur_step[1] ? a1_reg : a0_reg;
    assign op_b = cur_step[0] ? b1_reg : b0_reg;
    assign pp   = PW'(op_a) * PW'(op_b);

    // -------------------------------------------------------------------------
    // Shifted candidates, one per step
    //
    // Each candidate is the partial product moved to its digit weight:
    //   step0 -> weight 0, steps 1/2 -> weight WIDTH, step3 -> weight 2*WIDTH.
    // Only the candidate for the active step is added to the accumulator.
    // -------------------------------------------------------------------------
    logic [AW-1:0] pp_cand [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp_shift
            localparam int SH = (gi == 0) ? 0 :
                                (gi == 3) ? 2 * WIDTH : WIDTH;
            assign pp_cand[gi] = {{PW{1'b0}}, pp} << SH;
        end
    endgenerate

    logic [AW-1:0] pp_shifted;
    logic [AW-1:0] acc_sum;

    assign pp_shifted = pp_cand[cur_step];
    assign acc_sum    = acc_reg + pp_shifted;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Default: hold every register.
        state_next = state_reg;
        step_next  = step_reg;
        acc_next   = acc_reg;
        y_next     = y_reg;
        a1_next    = a1_reg;
        a0_next    = a0_reg;
        b1_next    = b1_reg;
        b0_next    = b0_reg;
`ifdef MUL4_SEQ_ZERO_SKIP_EN
        mask_next  = mask_reg;
`endif

        case (state_reg)
            // Wait for operands. in_ready is high only here.
            ST_IDLE: begin
                if (in_valid) begin
                    a1_next    = a1;
                    a0_next    = a0;
                    b1_next    = b1;
                    b0_next    = b0;
                    acc_next   = '0;
                    step_next  = 2'd0;
                    state_next = ST_MUL;
`ifdef MUL4_SEQ_ZERO_SKIP_EN
                    mask_next  = accept_mask;
                    // No contributing step: the product is zero.
                    if (accept_mask == 4'd0) begin
                        y_next     = '0;
                        state_next = ST_DONE;
                    end
`endif
                end
            end

            // One partial product per edge. The final sum goes straight to y,
            // so y never shows a partially accumulated value.
            ST_MUL: begin
                acc_next  = acc_sum;
                step_next = step_reg + 2'd1;
`ifdef MUL4_SEQ_ZERO_SKIP_EN
                mask_next = mask_reg & (mask_reg - 4'd1);
`endif
                if (last_step) begin
                    y_next     = acc_sum;
                    state_next = ST_DONE;
                end
            end

            // Hold the result until the consumer takes it. y is left intact
            // on exit; only out_valid drops. Operands arriving in the same
            // cycle are not accepted, because in_ready is low here.
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= 2'd0;
            acc_reg   <= '0;
            y_reg     <= '0;
            a1_reg    <= '0;
            a0_reg    <= '0;
            b1_reg    <= '0;
            b0_reg    <= '0;
`ifdef MUL4_SEQ_ZERO_SKIP_EN
            mask_reg  <= 4'd0;
`endif
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            acc_reg   <= acc_next;
            y_reg     <= y_next;
            a1_reg    <= a1_next;
            a0_reg    <= a0_next;
            b1_reg    <= b1_next;
            b0_reg    <= b0_next;
`ifdef MUL4_SEQ_ZERO_SKIP_EN
            mask_reg  <= mask_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all taken from registered state)
    // -------------------------------------------------------------------------
    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_MUL);
    assign out_valid = (state_reg == ST_DONE);

    // Split the result register into digits, y0 in the lowest WIDTH bits.
    logic [WIDTH-1:0] y_digit [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_y_split
            assign y_digit[gi] = y_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign y0 = y_digit[0];
    assign y1 = y_digit[1];
    assign y2 = y_digit[2];
    assign y3 = y_digit[3];

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul4_seq_ctrl
//
// Self-checking bench for mul4_seq_ctrl.
//
// The reference is the 64-bit integer product {a1,a0} * {b1,b0}. Latency is
// 4 edges after accept, or the number of contributing digit pairs when
// MUL4_SEQ_ZERO_SKIP_EN is defined.
//
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mul4_seq_ctrl;

    localparam int W = 16;

    // -------------------------------------------------------------------------
    // DUT connections and clock
    // -------------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a1, a0, b1, b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y3, y2, y1, y0;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul4_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a1        (a1),
        .a0        (a0),
        .b1        (b1),
        .b0        (b0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y3        (y3),
        .y2        (y2),
        .y1        (y1),
        .y0        (y0),
        .busy      (busy)
    );

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------

    // Full product of the two 2-digit numbers.
    function automatic logic [63:0] model_prod(input logic [W-1:0] ma1, ma0,
                                               input logic [W-1:0] mb1, mb0);
        logic [63:0] av;
        logic [63:0] bv;
        av = {32'd0, ma1, ma0};
        bv = {32'd0, mb1, mb0};
        return av * bv;
    endfunction

    // Edges from accept until out_valid is visible.
    function automatic int model_lat(input logic [W-1:0] ma1, ma0,
                                     input logic [W-1:0] mb1, mb0);
`ifdef MUL4_SEQ_ZERO_SKIP_EN
        int n;
        n = 0;
        if (ma0 != 0 && mb0 != 0) n++;
        if (ma0 != 0 && mb1 != 0) n++;
        if (ma1 != 0 && mb0 != 0) n++;
        if (ma1 != 0 && mb1 != 0) n++;
        return n;
`else
        return 4;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    function automatic logic [63:0] y_all();
        return {y3, y2, y1, y0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge, then scramble the inputs so that any
    // use of live inputs after accept shows up as a wrong result.
    task automatic issue(input logic [W-1:0] ia1, ia0, ib1, ib0);
        in_valid = 1'b1;
        a1 = ia1;
        a0 = ia0;
        b1 = ib1;
        b0 = ib0;
        tick();
        in_valid = 1'b0;
        a1 = W'($urandom);
        a0 = W'($urandom);
        b1 = W'($urandom);
        b0 = W'($urandom);
    endtask

    // Wait, with a bound, for out_valid. Counts the edges waited and the
    // cycles in which busy was seen. lat = -1 means the bound expired.
    task automatic wait_out(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------

    // Reset: handshake flags and the result digits.
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a1 = '0;
        a0 = '0;
        b1 = '0;
        b0 = '0;
        tick();
        tick();
        rst = 1'b0;

        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_flags: got rdy/val/busy=%b required 100",
                     {in_ready, out_valid, busy});
        end

        n_cmp++;
        if (y_all() !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_y: got %h required 0", y_all());
        end

        $display("reset: rdy=%b val=%b busy=%b y=%h",
                 in_ready, out_valid, busy, y_all());
    endtask

    // Directed vectors: maximum operands, small operands, shift path.
    task automatic test_directed();
        logic [W-1:0] va1 [3];
        logic [W-1:0] va0 [3];
        logic [W-1:0] vb1 [3];
        logic [W-1:0] vb0 [3];
        logic [63:0]  exp_y;
        int           lat;
        int           bcnt;
        int           exp_lat;

        va1 = '{16'hFFFF, 16'h0000, 16'h0001};
        va0 = '{16'hFFFF, 16'h0003, 16'h0000};
        vb1 = '{16'hFFFF, 16'h0000, 16'h0001};
        vb0 = '{16'hFFFF, 16'h0005, 16'h0000};

        for (int k = 0; k < 3; k++) begin
            exp_y   = model_prod(va1[k], va0[k], vb1[k], vb0[k]);
            exp_lat = model_lat(va1[k], va0[k], vb1[k], vb0[k]);

            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL dir%0d_in_ready: got %b required 1",
                         k, in_ready);
            end

            issue(va1[k], va0[k], vb1[k], vb0[k]);
            wait_out(lat, bcnt);

            n_cmp++;
            if (lat != exp_lat) begin
                n_bad++;
                $display("FAIL dir%0d_latency: got %0d required %0d",
                         k, lat, exp_lat);
            end

            n_cmp++;
            if (bcnt != exp_lat) begin
                n_bad++;
                $display("FAIL dir%0d_busy_cycles: got %0d required %0d",
                         k, bcnt, exp_lat);
            end

            n_cmp++;
            if (y_all() !== exp_y) begin
                n_bad++;
                $display("FAIL dir%0d_y: got %h required %h",
                         k, y_all(), exp_y);
            end

            // Release the result: out_valid drops, y keeps its value.
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;

            n_cmp++;
            if ({in_ready, out_valid} !== 2'b10 || y_all() !== exp_y) begin
                n_bad++;
                $display("FAIL dir%0d_release: got rdy/val=%b y=%h required 10 y=%h",
                         k, {in_ready, out_valid}, y_all(), exp_y);
            end

            $display("directed %0d: a=%h%h b=%h%h y=%h lat=%0d busy=%0d",
                     k, va1[k], va0[k], vb1[k], vb0[k], y_all(), lat, bcnt);
        end
    endtask

    // Backpressure in DONE, then a simultaneous output/input handshake.
    task automatic test_backpressure();
        logic [63:0] exp_y;
        logic [63:0] exp_y2;
        int          lat;
        int          bcnt;

        exp_y  = model_prod(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        exp_y2 = model_prod(16'h0102, 16'h0304, 16'h0506, 16'h0708);

        issue(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        wait_out(lat, bcnt);

        n_cmp++;
        if (lat < 0) begin
            n_bad++;
            $display("FAIL bp_timeout: got no out_valid required out_valid");
        end

        // Hold the result while the inputs toggle.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'($urandom);
            a1 = W'($urandom);
            a0 = W'($urandom);
            b1 = W'($urandom);
            b0 = W'($urandom);
            tick();

            n_cmp++;
            if (y_all() !== exp_y || {out_valid, in_ready} !== 2'b10) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got y=%h val/rdy=%b required y=%h 10",
                         c, y_all(), {out_valid, in_ready}, exp_y);
            end
        end

        // out_ready and in_valid together: only the output side completes.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a1 = 16'h0102;
        a0 = 16'h0304;
        b1 = 16'h0506;
        b0 = 16'h0708;
        tick();
        out_ready = 1'b0;

        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL bp_release: got rdy/val/busy=%b required 100",
                     {in_ready, out_valid, busy});
        end

        // The operands still on the inputs are accepted on this edge.
        tick();
        in_valid = 1'b0;

        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_next_accept: got busy=%b required 1", busy);
        end

        wait_out(lat, bcnt);

        n_cmp++;
        if (y_all() !== exp_y2) begin
            n_bad++;
            $display("FAIL bp_next_y: got %h required %h", y_all(), exp_y2);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("backpressure: held y=%h, next y=%h", exp_y, y_all());
    endtask

    // Reset in the second MUL cycle abandons the operation.
    task automatic test_reset_mid_op();
        int seen;

        issue(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;

        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100 || y_all() !== 64'd0) begin
            n_bad++;
            $display("FAIL midrst_state: got rdy/val/busy=%b y=%h required 100 y=0",
                     {in_ready, out_valid, busy}, y_all());
        end

        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) seen++;
        end

        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midrst_no_result: got out_valid for %0d cycles required 0",
                     seen);
        end

        $display("reset mid-op: rdy=%b val=%b y=%h", in_ready, out_valid, y_all());
    endtask

    // Random operands with random consumer stall.
    task automatic test_random();
        logic [W-1:0] r [4];
        logic [63:0]  exp_y;
        int           lat;
        int           bcnt;
        int           stall;

        for (int n = 0; n < 30; n++) begin
            // Zero digits are made frequent to exercise step skipping.
            for (int d = 0; d < 4; d++) begin
                r[d] = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
            end
            exp_y = model_prod(r[3], r[2], r[1], r[0]);

            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL rnd%0d_in_ready: got %b required 1", n, in_ready);
            end

            issue(r[3], r[2], r[1], r[0]);
            wait_out(lat, bcnt);

            n_cmp++;
            if (lat != model_lat(r[3], r[2], r[1], r[0])) begin
                n_bad++;
                $display("FAIL rnd%0d_latency: got %0d required %0d",
                         n, lat, model_lat(r[3], r[2], r[1], r[0]));
            end

            stall = $urandom_range(0, 3);
            for (int c = 0; c < stall; c++) begin
                tick();
            end

            n_cmp++;
            if (y_all() !== exp_y || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL rnd%0d_y: got y=%h val=%b required y=%h val=1",
                         n, y_all(), out_valid, exp_y);
            end

            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;

            $display("random %0d: a=%h%h b=%h%h y=%h lat=%0d stall=%0d",
                     n, r[3], r[2], r[1], r[0], y_all(), lat, stall);
        end
    endtask

    // Continuous in_valid/out_ready: accepts every 6 cycles.
    task automatic test_back_to_back();
        logic [63:0] exp_y;
        int          acc_t [$];
        int          good;

        exp_y     = model_prod(16'hA5A5, 16'h0F0F, 16'h3C3C, 16'h7777);
        in_valid  = 1'b1;
        a1 = 16'hA5A5;
        a0 = 16'h0F0F;
        b1 = 16'h3C3C;
        b0 = 16'h7777;
        out_ready = 1'b1;
        good      = 1;

        for (int t = 0; t < 20; t++) begin
            if (in_ready) acc_t.push_back(t);
            if (out_valid && y_all() !== exp_y) good = 0;
            tick();
        end
        in_valid = 1'b0;

        n_cmp++;
        if (acc_t.size() < 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d accepts required >=3", acc_t.size());
        end else begin
            for (int i = 1; i < acc_t.size(); i++) begin
                n_cmp++;
                if (acc_t[i] - acc_t[i-1] != 6) begin
                    n_bad++;
                    $display("FAIL b2b_interval%0d: got %0d required 6",
                             i, acc_t[i] - acc_t[i-1]);
                end
            end
        end

        n_cmp++;
        if (good != 1) begin
            n_bad++;
            $display("FAIL b2b_y: got a wrong result %h required %h",
                     y_all(), exp_y);
        end

        for (int c = 0; c < 8; c++) begin
            tick();
        end
        out_ready = 1'b0;

        $display("back_to_back: %0d accepts in 20 cycles", acc_t.size());
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a1 = '0;
        a0 = '0;
        b1 = '0;
        b0 = '0;

        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
